k_gain_computer: RTL and testbench
==================================

// Module: k_gain_computer
// PURPOSE
//  Downstream consumer of the energy stream (energy + 1-cycle valid pulse) in the audio compressor.
//  - Smooths incoming energy into an attack/release envelope.
//  - Computes a power-domain gain: gain = min(1.0, threshold/envelope), unsigned Q1.(GAIN_WIDTH-1).
//  - Division is a sequential restoring divider; results go to the gain-apply stage.
// PARAMETERS
//  IN_WIDTH    40  width of in_energy, threshold and envelope (unsigned)
//  GAIN_WIDTH  16  width of out_gain; 1.0 = 1<<(GAIN_WIDTH-1); divide takes GAIN_WIDTH cycles
//  ATK_SHIFT   2   attack smoothing shift (envelope rising)
//  REL_SHIFT   6   release smoothing shift (envelope falling)
// PORTS
//  clk          in   1           single clock, all logic on rising edge
//  resetn       in   1           synchronous, active-low reset
//  in_energy    in   IN_WIDTH    unsigned energy sample
//  in_valid     in   1           1-cycle pulse: in_energy valid this cycle
//  threshold    in   IN_WIDTH    unsigned energy threshold, sampled in CHECK
//  out_gain     out  GAIN_WIDTH  unsigned gain, Q1.(GAIN_WIDTH-1); held between updates
//  out_valid    out  1           1-cycle pulse: out_gain updated
//  out_env      out  IN_WIDTH    current envelope register (debug/metering)
//  busy         out  1           high in CHECK and DIVIDE
// BEHAVIOUR
//  Reset (resetn=0 at an edge), from any state incl. mid-divide:
//   - state=IDLE, env=0, pending=0, out_gain=1<<(GAIN_WIDTH-1), out_valid=0, busy=0
//   - no result is emitted for an aborted division
//  Envelope: updated on every edge with in_valid=1, in any state:
//   - e>env:  env <= env + ((e-env)>>ATK_SHIFT)
//   - e<=env: env <= env - ((env-e)>>REL_SHIFT)
//   - result always lies between env and e: no overflow, no extra bits
//  States: IDLE, CHECK, DIVIDE.
//   - IDLE:   in_valid -> CHECK
//   - CHECK:  snapshot D=env, T=threshold
//             if D<=T (incl. D=0): out_gain<=1.0, out_valid<=1, then IDLE (CHECK if pending|in_valid)
//             else: start divide, cnt=0, -> DIVIDE
//   - DIVIDE: GAIN_WIDTH cycles, one quotient bit per cycle, MSB first
//             result q = floor(T * 2^(GAIN_WIDTH-1) / D); q MSB always 0 since T<D
//             remainder width IN_WIDTH+1; T=0 gives q=0; no divide-by-zero possible (D>T>=0)
//             last cycle: out_gain<=q, out_valid<=1; next CHECK if pending|in_valid, else IDLE
//  Latency (in_valid in cycle N, from IDLE): out_valid in N+2 (bypass) or N+2+GAIN_WIDTH (divide)
//  Backlog:
//   - in_valid during CHECK/DIVIDE: updates env, sets pending
//   - the running division keeps its snapshot
//   - multiple valids collapse into one pending result
//   - pending cleared on entering CHECK
//  in_valid on the final DIVIDE cycle: env updated, goes straight to CHECK
//  out_valid is never high on two consecutive cycles; out_gain changes only with out_valid
// TESTING
//  1 reset; thr=4000; in_energy=1000 pulse
//    -> env=250, out_valid at N+2, out_gain=0x8000, busy never high during DIVIDE
//  2 reset; thr=500; in_energy=4000 pulse
//    -> env=1000, busy N+1..N+17, out_valid at N+18, out_gain=0x4000
//  3 continue test 2; thr=500; second 4000 pulse at N+5 (mid-divide), third at N+9
//    -> first result 0x4000; env=1750 then 2312 (two attack updates: 1000->1750->2312)
//    -> exactly one extra result, out_gain = floor(500*32768/2312) = 7086 = 0x1BAE
//  4 env=1000; thr=2000; in_energy=0 pulse
//    -> env=985 (release step 15), out_gain=0x8000 bypass
//  5 thr=0; env=1000 after pulse -> divide path, out_gain=0x0000 at N+18
//  6 reset asserted mid-DIVIDE (cycle N+8)
//    -> no out_valid, out_gain=0x8000, env=0, busy=0 the cycle after the reset edge

Source files
------------

// File: rtl/k_gain_computer.sv
// Gain computer: attack/release envelope follower feeding a sequential restoring
// divider that produces gain = min(1.0, threshold/envelope) in unsigned Q1.(GAIN_WIDTH-1).
module k_gain_computer #(
  parameter int IN_WIDTH   = 40,
  parameter int GAIN_WIDTH = 16,
  parameter int ATK_SHIFT  = 2,
  parameter int REL_SHIFT  = 6
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [IN_WIDTH-1:0]   in_energy,
  input  logic                  in_valid,
  input  logic [IN_WIDTH-1:0]   threshold,
  output logic [GAIN_WIDTH-1:0] out_gain,
  output logic                  out_valid,
  output logic [IN_WIDTH-1:0]   out_env,
  output logic                  busy
);

  localparam int CNT_W = (GAIN_WIDTH > 1) ? $clog2(GAIN_WIDTH) : 1;
  localparam logic [GAIN_WIDTH-1:0] GAIN_ONE = {1'b1, {(GAIN_WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(GAIN_WIDTH-1);

  typedef enum logic [1:0] {IDLE, CHECK, DIVIDE} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [IN_WIDTH-1:0]   r_env;
  logic                  r_pending;
  logic [GAIN_WIDTH-1:0] r_gain;
  logic                  r_out_valid;
  logic [CNT_W-1:0]      r_cnt;
  logic [IN_WIDTH:0]     r_rem;
  logic [IN_WIDTH-1:0]   r_den;
  logic [GAIN_WIDTH-1:0] r_quo;

  logic                  w_env_up;
  logic [IN_WIDTH-1:0]   w_diff;
  logic [IN_WIDTH-1:0]   w_env_next;
  logic [IN_WIDTH:0]     w_rem_shift;
  logic                  w_ge;
  logic [IN_WIDTH:0]     w_rem_next;
  logic [GAIN_WIDTH-1:0] w_quo_next;
  logic                  w_bypass;
  logic                  w_hold;
  logic                  w_last;
  logic                  w_more;
  logic                  w_enter_check;
  logic                  w_pending_next;
  logic                  w_busy;

  // The step is a shifted fraction of |e-env|, so the result stays between env and e.
  assign w_env_up   = in_energy > r_env;
  assign w_diff     = w_env_up ? (in_energy - r_env) : (r_env - in_energy);
  assign w_env_next = w_env_up ? (r_env + (w_diff >> ATK_SHIFT))
                               : (r_env - (w_diff >> REL_SHIFT));

  // First divide cycle compares the unshifted remainder (quotient MSB, always 0 since T<D).
  assign w_rem_shift = (r_cnt == '0) ? r_rem : {r_rem[IN_WIDTH-1:0], 1'b0};
  assign w_ge        = w_rem_shift >= {1'b0, r_den};
  assign w_rem_next  = w_ge ? (w_rem_shift - {1'b0, r_den}) : w_rem_shift;
  assign w_quo_next  = {r_quo[GAIN_WIDTH-2:0], w_ge};
  assign w_last      = r_cnt == CNT_LAST;

  // A bypass result right after another result waits one cycle so out_valid never repeats.
  assign w_bypass = r_env <= threshold;
  assign w_hold   = w_bypass && r_out_valid;
  assign w_more   = r_pending || in_valid;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_state_next = CHECK;
      CHECK: begin
        if (w_hold)        w_state_next = CHECK;
        else if (w_bypass) w_state_next = w_more ? CHECK : IDLE;
        else               w_state_next = DIVIDE;
      end
      DIVIDE:  if (w_last) w_state_next = w_more ? CHECK : IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_busy        = 1'b0;
    w_enter_check = 1'b0;
    case (r_state)
      IDLE:    w_enter_check = (w_state_next == CHECK);
      CHECK: begin
        w_busy        = 1'b1;
        w_enter_check = !w_hold && (w_state_next == CHECK);
      end
      DIVIDE: begin
        w_busy        = 1'b1;
        w_enter_check = (w_state_next == CHECK);
      end
      default: begin
        w_busy        = 1'b0;
        w_enter_check = 1'b0;
      end
    endcase
  end

  assign w_pending_next = w_enter_check ? 1'b0
                        : (r_pending || (in_valid && (r_state != IDLE)));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_env       <= '0;
      r_pending   <= 1'b0;
      r_gain      <= GAIN_ONE;
      r_out_valid <= 1'b0;
      r_cnt       <= '0;
      r_rem       <= '0;
      r_den       <= '0;
      r_quo       <= '0;
    end else begin
      r_out_valid <= 1'b0;
      r_pending   <= w_pending_next;
      if (in_valid) begin
        r_env <= w_env_next;
      end
      case (r_state)
        CHECK: begin
          if (!w_hold) begin
            if (w_bypass) begin
              r_gain      <= GAIN_ONE;
              r_out_valid <= 1'b1;
            end else begin
              r_den <= r_env;
              r_rem <= {1'b0, threshold};
              r_cnt <= '0;
              r_quo <= '0;
            end
          end
        end
        DIVIDE: begin
          r_rem <= w_rem_next;
          r_quo <= w_quo_next;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_gain      <= w_quo_next;
            r_out_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_gain  = r_gain;
  assign out_valid = r_out_valid;
  assign out_env   = r_env;
  assign busy      = w_busy;

endmodule

// File: tb/tb_k_gain_computer.sv
// Directed bench for k_gain_computer: envelope steps, bypass and divide results,
// backlog collapsing, result spacing and reset abort.
module tb_k_gain_computer;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [39:0] in_energy = '0;
  logic        in_valid = 1'b0;
  logic [39:0] threshold = '0;
  logic [15:0] out_gain;
  logic        out_valid;
  logic [39:0] out_env;
  logic        busy;

  int checks = 0;
  int errors = 0;

  k_gain_computer #(
    .IN_WIDTH(40), .GAIN_WIDTH(16), .ATK_SHIFT(2), .REL_SHIFT(6)
  ) dut (
    .clk(clk), .resetn(resetn), .in_energy(in_energy), .in_valid(in_valid),
    .threshold(threshold), .out_gain(out_gain), .out_valid(out_valid),
    .out_env(out_env), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives a one-cycle pulse in cycle N; returns sampled in cycle N+1.
  task automatic pulse(input logic [39:0] e);
    in_energy = e;
    in_valid  = 1'b1;
    step();
    in_valid  = 1'b0;
  endtask

  task automatic do_reset();
    resetn   = 1'b0;
    in_valid = 1'b0;
    step(2);
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (out_gain !== 16'h8000 || out_valid !== 1'b0 || busy !== 1'b0 || out_env !== 40'd0) begin
      errors++;
      $display("FAIL reset: gain=%h valid=%b busy=%b env=%0d, need 8000/0/0/0",
               out_gain, out_valid, busy, out_env);
    end
    $display("test_reset: gain=%h env=%0d", out_gain, out_env);
  endtask

  task automatic test_bypass();
    do_reset();
    threshold = 40'd4000;
    pulse(40'd1000);
    checks++;
    if (out_env !== 40'd250 || busy !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bypass_check: env=%0d busy=%b valid=%b, need 250/1/0", out_env, busy, out_valid);
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || out_gain !== 16'h8000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bypass_result: valid=%b gain=%h busy=%b, need 1/8000/0", out_valid, out_gain, busy);
    end
    step();
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bypass_after: valid=%b busy=%b, need 0/0", out_valid, busy);
    end
    $display("test_bypass: env=%0d gain=%h", out_env, out_gain);
  endtask

  task automatic test_divide();
    int bad;
    do_reset();
    threshold = 40'd500;
    pulse(40'd4000);
    checks++;
    if (out_env !== 40'd1000) begin
      errors++;
      $display("FAIL divide_env: env=%0d need 1000", out_env);
    end
    bad = 0;
    for (int k = 1; k <= 17; k++) begin
      if (busy !== 1'b1 || out_valid !== 1'b0) bad++;
      step();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL divide_busy: %0d bad cycles in N+1..N+17, need 0", bad);
    end
    checks++;
    if (out_valid !== 1'b1 || out_gain !== 16'h4000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL divide_result: valid=%b gain=%h busy=%b, need 1/4000/0", out_valid, out_gain, busy);
    end
    $display("test_divide: gain=%h", out_gain);
  endtask

  task automatic test_backlog();
    int pulses;
    do_reset();
    threshold = 40'd500;
    pulse(40'd4000);              // N -> now N+1
    step(4);                      // N+5
    pulse(40'd4000);              // -> N+6
    checks++;
    if (out_env !== 40'd1750) begin
      errors++;
      $display("FAIL backlog_env1: env=%0d need 1750", out_env);
    end
    step(3);                      // N+9
    pulse(40'd4000);              // -> N+10
    checks++;
    if (out_env !== 40'd2312) begin
      errors++;
      $display("FAIL backlog_env2: env=%0d need 2312", out_env);
    end
    step(8);                      // N+18
    checks++;
    if (out_valid !== 1'b1 || out_gain !== 16'h4000 || busy !== 1'b1) begin
      errors++;
      $display("FAIL backlog_first: valid=%b gain=%h busy=%b, need 1/4000/1", out_valid, out_gain, busy);
    end
    pulses = 0;
    for (int k = 0; k < 17; k++) begin
      step();
      if (out_valid === 1'b1) pulses++;
    end                           // N+35
    checks++;
    if (out_valid !== 1'b1 || out_gain !== 16'h1BAE || pulses != 1) begin
      errors++;
      $display("FAIL backlog_second: valid=%b gain=%h pulses=%0d, need 1/1bae/1",
               out_valid, out_gain, pulses);
    end
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (out_valid === 1'b1 || busy === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL backlog_extra: %0d extra valid/busy cycles, need 0", pulses);
    end
    $display("test_backlog: gain=%h env=%0d", out_gain, out_env);
  endtask

  task automatic test_back_to_back();
    logic [3:0] seen;
    do_reset();
    threshold = 40'd4000;
    pulse(40'd1000);              // N -> N+1 (CHECK)
    pulse(40'd1000);              // pending during CHECK -> N+2
    checks++;
    if (out_env !== 40'd437) begin
      errors++;
      $display("FAIL b2b_env: env=%0d need 437", out_env);
    end
    seen = '0;
    for (int k = 0; k < 4; k++) begin
      seen[k] = out_valid;
      if (k < 3) step();
    end
    checks++;
    if (seen !== 4'b0101 || out_gain !== 16'h8000) begin
      errors++;
      $display("FAIL b2b_spacing: valid N+5..N+2=%b gain=%h, need 0101/8000", seen, out_gain);
    end
    $display("test_back_to_back: valids=%b", seen);
  endtask

  task automatic test_zero_threshold();
    do_reset();
    threshold = 40'd0;
    pulse(40'd4000);
    step(17);                     // N+18
    checks++;
    if (out_valid !== 1'b1 || out_gain !== 16'h0000 || out_env !== 40'd1000) begin
      errors++;
      $display("FAIL zero_thr: valid=%b gain=%h env=%0d, need 1/0000/1000", out_valid, out_gain, out_env);
    end
    step();
    $display("test_zero_threshold: gain=%h", out_gain);
  endtask

  task automatic test_release();
    threshold = 40'd2000;         // env 1000, gain 0000 from previous test
    pulse(40'd0);
    checks++;
    if (out_env !== 40'd985) begin
      errors++;
      $display("FAIL release_env: env=%0d need 985", out_env);
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || out_gain !== 16'h8000) begin
      errors++;
      $display("FAIL release_result: valid=%b gain=%h, need 1/8000", out_valid, out_gain);
    end
    $display("test_release: env=%0d gain=%h", out_env, out_gain);
  endtask

  task automatic test_reset_mid_divide();
    int pulses;
    do_reset();
    threshold = 40'd500;
    pulse(40'd4000);              // N+1
    step(7);                      // N+8
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_pre: busy=%b need 1", busy);
    end
    resetn = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b0 || out_gain !== 16'h8000 || out_env !== 40'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_reset: valid=%b gain=%h env=%0d busy=%b, need 0/8000/0/0",
               out_valid, out_gain, out_env, busy);
    end
    resetn = 1'b1;
    pulses = 0;
    for (int k = 0; k < 25; k++) begin
      step();
      if (out_valid === 1'b1 || busy === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL abort_after: %0d valid/busy cycles, need 0", pulses);
    end
    $display("test_reset_mid_divide: gain=%h env=%0d", out_gain, out_env);
  endtask

  initial begin
    step();
    test_reset();
    test_bypass();
    test_divide();
    test_backlog();
    test_back_to_back();
    test_zero_threshold();
    test_release();
    test_reset_mid_divide();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
